// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU ops,
// state encoding and fault codes.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b100001;
    localparam logic [5:0] OP_BEQ   = 6'b100011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    typedef enum logic [3:0] {
        S_BOOT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_t;

    // States that hold a memory request open and are watched for timeout.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive cycles a memory request waits for mem_ready and
// flags a timeout on the cycle the count reaches MEM_TIMEOUT without ready.
module mem_wait_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] count;

    // Clearing whenever idle or on completion means every wait state is
    // entered with a zero count, including the MEM_WR -> FETCH hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || mem_ready) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle control FSM: sequences fetch/decode/execute over
// a shared datapath, with memory watchdog, halt/fault and retire count.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instr_retired,
    output logic [3:0]       state_o
);

    state_t state, next_state;
    fault_t fault_q, next_fault;
    logic   retire;
    logic   timeout;

    mem_wait_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (is_mem_wait(state)),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    // State and latched fault code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_BOOT;
            fault_q <= FAULT_NONE;
        end else begin
            state   <= next_state;
            fault_q <= next_fault;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_retired <= '0;
        end else if (retire) begin
            instr_retired <= instr_retired + 1'b1;
        end
    end

    // Next-state logic and per-state control word.
    always_comb begin
        next_state    = state;
        next_fault    = fault_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        halted        = 1'b0;
        case (state)
            S_BOOT: next_state = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = S_HALT;
                    next_fault = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     next_state = S_EXEC_R;
                    OP_LW, OP_SW: next_state = S_ADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_HALT: begin
                        next_state = S_HALT;
                        next_fault = FAULT_NONE;
                    end
                    default: begin
                        next_state = S_HALT;
                        next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                next_state = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = S_WB_MEM;
                end else if (timeout) begin
                    next_state = S_HALT;
                    next_fault = FAULT_TIMEOUT;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state = S_HALT;
                    next_fault = FAULT_TIMEOUT;
                end
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: next_state = S_BOOT;
        endcase
    end

    assign fault   = fault_q;
    assign state_o = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style FSM that sequences the shared datapath (single ALU, single unified memory port, register file, PC/IR) one instruction over several cycles. Replaces per-instruction combinational decode with state-by-state control words. Talks to memory over a req/ready handshake with a watchdog timeout. Reports halt/fault status and a retired-instruction count.

Parameters:
MEM_TIMEOUT, 15, max consecutive cycles waiting for mem_ready before fault; 0 disables the watchdog.
CNT_W, 32, width of instr_retired.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from the DECODE state onward
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  1 = write access (valid with mem_req)
iord  out  1  memory address source: 0 = PC, 1 = ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  3  ALU_ADD / ALU_SUB / ALU_FUNCT
reg_write  out  1  register file write enable
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
halted  out  1  sticky; controller stopped
fault  out  2  00 clean halt, 01 illegal opcode, 10 memory timeout
instr_retired  out  CNT_W  retired instruction count
state_o  out  4  current state encoding, debug

Behaviour:
- Reset (async, rst_n=0): state=BOOT, instr_retired=0, wait counter=0, fault=00, halted=0, every control output 0 (alu_op=ALU_ADD=000). Reset mid-access drops mem_req at once; no retire counted.
- Outputs are a function of state only, except ir_write/pc_write in FETCH, which are qualified by mem_ready.
- BOOT: all controls 0. Next FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00. If mem_ready: ir_write=1, pc_write=1, next DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target precompute). Next state by opcode:
  - RTYPE 000000 -> EXEC_R
  - LW 001000 or SW 100001 -> ADDR
  - BEQ 100011 -> BRANCH
  - J 000010 -> JUMP
  - HALT 111111 -> HALT with fault=00
  - any other value -> HALT with fault=01
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNCT. Next WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Retire. Next FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, iord=1, mem_we=0. Next WB_MEM on mem_ready.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Retire. Next FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1. On mem_ready: retire, next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_src=01. Retire. Next FETCH.
- JUMP: pc_write=1, pc_src=10. Retire. Next FETCH.
- HALT: all controls 0, halted=1. Absorbing until reset. fault latched on entry.
- Handshake: mem_req never drops before mem_ready is seen. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored. mem_ready in the first wait cycle gives a 1-cycle access.
- Watchdog:
  - counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_ready=0 there.
  - when counter==MEM_TIMEOUT and mem_ready=0: go to HALT with fault=10.
  - mem_ready in that same cycle wins (normal completion).
- Retire: instr_retired increments by 1 in the final cycle of each instruction and wraps modulo 2^CNT_W. HALT/illegal opcodes do not retire.
- CPI with zero-wait memory: R=4, LW=5, SW=4, BEQ=3, J=3.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT
  - ALU_ADD=000, ALU_SUB=001, ALU_FUNCT=111
  - state encoding constants
  - fault codes
- One natural sub-module: mem_wait_watchdog (counter, clear/enable, timeout flag).

Test Plan:
- Reset then zero-wait memory, opcode=000000: states BOOT,FETCH,DECODE,EXEC_R,WB_R; reg_write=1 and reg_dst=1 only in WB_R; instr_retired=1 after 5 cycles.
- LW with mem_ready delayed 3 cycles in MEM_RD: mem_req=1, iord=1 held for 4 cycles; WB_MEM has mem_to_reg=1; instr_retired increments once.
- SW, BEQ, J back-to-back with zero wait: mem_we=1 only in MEM_WR; pc_write_cond=1 with alu_op=001 in BRANCH; pc_src=10 in JUMP; instr_retired=3.
- Opcode 010101: HALT, halted=1, fault=01, all controls 0 for 20 cycles, instr_retired unchanged.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH: HALT with fault=10 after 16 wait cycles. Repeat with mem_ready on cycle 16: normal DECODE.
- rst_n pulsed low mid-MEM_WR: mem_req falls asynchronously; after release the sequence restarts at BOOT with instr_retired=0.
